aes_cipher_core: RTL and testbench

Iterative AES-128 encryption datapath, one round per clock. It sits directly downstream of the key expansion block and consumes its round-key stream (one 128-bit round key per cycle, qualified by the expander's 2-bit state output). Plaintext is latched on the same start pulse that launches key expansion. The ciphertext is produced 12 cycles after start.

---
 rtl/aes_cipher_core.sv | 169 ++++++++++++++++
 tb/tb_aes_cipher_core.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption datapath: one round per clock, fed by the key
// expansion round-key stream. Ciphertext appears 12 cycles after start_in.
module aes_cipher_core #(
    parameter int unsigned NR = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start_in,
    input  logic [31:0] pt0_in,
    input  logic [31:0] pt1_in,
    input  logic [31:0] pt2_in,
    input  logic [31:0] pt3_in,
    input  logic [31:0] rkey0_in,
    input  logic [31:0] rkey1_in,
    input  logic [31:0] rkey2_in,
    input  logic [31:0] rkey3_in,
    input  logic [1:0]  key_state_in,
    output logic [31:0] ct0_out,
    output logic [31:0] ct1_out,
    output logic [31:0] ct2_out,
    output logic [31:0] ct3_out,
    output logic        valid_out,
    output logic        busy_out,
    output logic [3:0]  round_out
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StRound = 2'd2;
    localparam logic [1:0] StFinal = 2'd3;

    localparam logic [1:0] KsRound0    = 2'd1;
    localparam logic [1:0] KsRound1to9 = 2'd2;
    localparam logic [1:0] KsRound10   = 2'd3;

    // S-box entry x sits at bits [8*(255-x)+7 -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] ct_q, ct_d;
    logic [3:0]   round_q, round_d;
    logic         valid_q, valid_d;

    logic [127:0] rkey;
    logic [31:0]  sb_w [4];
    logic [127:0] sr_state;
    logic [127:0] mc_state;

    assign rkey = {rkey0_in, rkey1_in, rkey2_in, rkey3_in};

    always_comb begin
        sr_state = '0;
        mc_state = '0;
        for (int c = 0; c < 4; c++) begin
            sb_w[c] = sub_word(state_q[127 - 32 * c -: 32]);
        end
        // Row r of column c comes from column c+r.
        for (int c = 0; c < 4; c++) begin
            sr_state[127 - 32 * c -: 32] = {sb_w[c][31:24], sb_w[2'(c + 1)][23:16],
                                            sb_w[2'(c + 2)][15:8], sb_w[2'(c + 3)][7:0]};
            mc_state[127 - 32 * c -: 32] = mix_column(sr_state[127 - 32 * c -: 32]);
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        round_d = round_q;
        valid_d = 1'b0;
        case (fsm_q)
            StIdle: begin
                if (start_in) begin
                    pt_d  = {pt0_in, pt1_in, pt2_in, pt3_in};
                    fsm_d = StLoad;
                end
            end
            StLoad: begin
                if (key_state_in != KsRound0) begin
                    fsm_d = StIdle;
                end else begin
                    state_d = pt_q ^ rkey;
                    round_d = 4'd1;
                    fsm_d   = StRound;
                end
            end
            StRound: begin
                if (key_state_in != KsRound1to9) begin
                    fsm_d   = StIdle;
                    round_d = 4'd0;
                end else begin
                    state_d = mc_state ^ rkey;
                    round_d = round_q + 4'd1;
                    if (round_q == 4'(NR - 1)) begin
                        fsm_d = StFinal;
                    end
                end
            end
            default: begin
                fsm_d   = StIdle;
                round_d = 4'd0;
                if (key_state_in == KsRound10) begin
                    ct_d    = sr_state ^ rkey;
                    valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            round_q <= round_d;
            valid_q <= valid_d;
        end
    end

    assign {ct0_out, ct1_out, ct2_out, ct3_out} = ct_q;
    assign valid_out = valid_q;
    assign busy_out  = (fsm_q != StIdle);
    assign round_out = round_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: emulates the key expander, keeps a byte-level AES
// reference model and checks every cycle, plus FIPS-197 literal vectors.
module tb_aes_cipher_core;

    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ST0_B   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] K10_B   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start_in;
    logic [31:0] pt0_in, pt1_in, pt2_in, pt3_in;
    logic [31:0] rkey0_in, rkey1_in, rkey2_in, rkey3_in;
    logic [1:0]  key_state_in;
    logic [31:0] ct0_out, ct1_out, ct2_out, ct3_out;
    logic        valid_out, busy_out;
    logic [3:0]  round_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sb_m [256];
    logic [127:0] cur_key, ks_key;
    int           ks_cnt, force_cnt;

    logic         m_active, m_valid;
    int           m_age;
    logic [127:0] m_pt, m_key, m_ct;

    aes_cipher_core #(.NR(10)) dut (
        .CLK(CLK), .RST(RST), .start_in(start_in),
        .pt0_in(pt0_in), .pt1_in(pt1_in), .pt2_in(pt2_in), .pt3_in(pt3_in),
        .rkey0_in(rkey0_in), .rkey1_in(rkey1_in), .rkey2_in(rkey2_in), .rkey3_in(rkey3_in),
        .key_state_in(key_state_in),
        .ct0_out(ct0_out), .ct1_out(ct1_out), .ct2_out(ct2_out), .ct3_out(ct3_out),
        .valid_out(valid_out), .busy_out(busy_out), .round_out(round_out)
    );

    always #5 CLK = ~CLK;

    // Carry-less multiply then reduce modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'(9'h11b) << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int idx);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb_m[tmp[23:16]], sb_m[tmp[15:8]], sb_m[tmp[7:0]], sb_m[tmp[31:24]]}
                      ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        return {w[4 * idx], w[4 * idx + 1], w[4 * idx + 2], w[4 * idx + 3]};
    endfunction

    // Byte b of the block is row b%4 of column b/4.
    function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] rk;
        rk = round_key(key, 0);
        for (int b = 0; b < 16; b++) s[b] = pt[127 - 8 * b -: 8] ^ rk[127 - 8 * b -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int b = 0; b < 16; b++) t[b] = sb_m[s[b]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * ((c + r) % 4) + r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4 * c + r];
                    for (int r = 0; r < 4; r++)
                        s[4 * c + r] = gmul(a[r], 8'h02) ^ gmul(a[(r + 1) % 4], 8'h03)
                                       ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
                end
            end
            rk = round_key(key, rnd);
            for (int b = 0; b < 16; b++) s[b] ^= rk[127 - 8 * b -: 8];
        end
        for (int b = 0; b < 16; b++) rk[127 - 8 * b -: 8] = s[b];
        return rk;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: advance the emulated key expander, then present the next inputs.
    task automatic drive_cycle(input logic st, input logic [127:0] pt);
        @(negedge CLK);
        #1;
        if (!RST) ks_cnt = -1;
        else if (ks_cnt >= 0) ks_cnt = (ks_cnt == 10) ? -1 : ks_cnt + 1;
        else if (start_in) begin
            ks_cnt = 0;
            ks_key = cur_key;
        end
        if (ks_cnt < 0 || ks_cnt == force_cnt) begin
            key_state_in = 2'd0;
            {rkey0_in, rkey1_in, rkey2_in, rkey3_in} = '0;
        end else begin
            key_state_in = (ks_cnt == 0) ? 2'd1 : (ks_cnt == 10) ? 2'd3 : 2'd2;
            {rkey0_in, rkey1_in, rkey2_in, rkey3_in} = round_key(ks_key, ks_cnt);
        end
        start_in = st;
        {pt0_in, pt1_in, pt2_in, pt3_in} = pt;
    endtask

    // Reference model: tracks cycles since an accepted start and the last ciphertext.
    initial begin
        m_active = 1'b0;
        m_valid  = 1'b0;
        m_age    = 0;
        m_pt     = '0;
        m_key    = '0;
        m_ct     = '0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                m_active = 1'b0;
                m_valid  = 1'b0;
                m_age    = 0;
                m_ct     = '0;
            end else begin
                m_valid = 1'b0;
                if (m_active) begin
                    if (key_state_in != ((m_age == 1) ? 2'd1 : (m_age == 11) ? 2'd3 : 2'd2)) begin
                        m_active = 1'b0;
                    end else if (m_age == 11) begin
                        m_active = 1'b0;
                        m_valid  = 1'b1;
                        m_ct     = aes_encrypt(m_key, m_pt);
                    end else begin
                        m_age++;
                    end
                end else if (start_in) begin
                    m_active = 1'b1;
                    m_age    = 1;
                    m_pt     = {pt0_in, pt1_in, pt2_in, pt3_in};
                    m_key    = cur_key;
                end
            end
            check("valid_out", 128'(valid_out), 128'(m_valid));
            check("busy_out", 128'(busy_out), 128'(m_active));
            check("round_out", 128'(round_out),
                  128'(!m_active ? 0 : (m_age == 1) ? 0 : (m_age == 11) ? 10 : m_age - 1));
            check("ct_out", {ct0_out, ct1_out, ct2_out, ct3_out}, m_ct);
        end
    end

    initial begin
        for (int x = 0; x < 256; x++) sb_m[x] = sbox_calc(8'(x));
        RST          = 1'b0;
        start_in     = 1'b0;
        key_state_in = 2'd0;
        {pt0_in, pt1_in, pt2_in, pt3_in} = '0;
        {rkey0_in, rkey1_in, rkey2_in, rkey3_in} = '0;
        ks_cnt    = -1;
        force_cnt = -2;
        cur_key   = KEY_B;
        ks_key    = KEY_B;

        check("model_sbox_00", 128'(sb_m[0]), 128'h63);
        check("model_sbox_53", 128'(sb_m[8'h53]), 128'hed);
        check("model_k10_b", round_key(KEY_B, 10), K10_B);
        check("model_ct_b", aes_encrypt(KEY_B, PT_B), CT_B);
        check("model_ct_c", aes_encrypt(KEY_C, PT_C), CT_C);

        #2;
        check("rst_ct", {ct0_out, ct1_out, ct2_out, ct3_out}, '0);
        check("rst_flags", {124'd0, valid_out, busy_out, 2'b00}, '0);
        repeat (3) drive_cycle(1'b0, rnd128());
        RST = 1'b1;
        repeat (2) drive_cycle(1'b0, rnd128());

        // App. B with latency and internal state checks.
        cur_key = KEY_B;
        drive_cycle(1'b1, PT_B);
        for (int k = 1; k <= 12; k++) begin
            drive_cycle(1'b0, rnd128());
            if (k == 2) check("state_after_load", dut.state_q, ST0_B);
            if (k >= 2 && k <= 11) check("round_step", 128'(round_out), 128'(k - 1));
            if (k == 11) check("valid_before_t12", 128'(valid_out), 128'd0);
        end
        check("valid_b", 128'(valid_out), 128'd1);
        check("ct_b", {ct0_out, ct1_out, ct2_out, ct3_out}, CT_B);

        // App. C.1 back-to-back, started one cycle after valid_out.
        cur_key = KEY_C;
        drive_cycle(1'b1, PT_C);
        repeat (12) drive_cycle(1'b0, rnd128());
        check("valid_c", 128'(valid_out), 128'd1);
        check("ct_c", {ct0_out, ct1_out, ct2_out, ct3_out}, CT_C);

        // Second start at T+5 is ignored.
        drive_cycle(1'b0, rnd128());
        cur_key = KEY_B;
        drive_cycle(1'b1, PT_B);
        for (int k = 1; k <= 12; k++) drive_cycle(k == 5, (k == 5) ? PT_C : rnd128());
        check("ct_b_ignored_start", {ct0_out, ct1_out, ct2_out, ct3_out}, CT_B);

        // Key stream drops to IDLE at T+6: abort, ciphertext retained.
        drive_cycle(1'b0, rnd128());
        cur_key   = KEY_C;
        force_cnt = 5;
        drive_cycle(1'b1, PT_C);
        repeat (7) drive_cycle(1'b0, rnd128());
        check("abort_busy", 128'(busy_out), 128'd0);
        check("abort_ct_hold", {ct0_out, ct1_out, ct2_out, ct3_out}, CT_B);
        force_cnt = -2;
        repeat (8) drive_cycle(1'b0, rnd128());
        check("abort_no_valid", 128'(valid_out), 128'd0);
        check("abort_ct_final", {ct0_out, ct1_out, ct2_out, ct3_out}, CT_B);

        // Asynchronous reset mid-encryption at T+8.
        cur_key = KEY_B;
        drive_cycle(1'b1, PT_B);
        repeat (7) drive_cycle(1'b0, rnd128());
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("midrst_ct", {ct0_out, ct1_out, ct2_out, ct3_out}, '0);
        check("midrst_valid", 128'(valid_out), 128'd0);
        check("midrst_busy", 128'(busy_out), 128'd0);
        check("midrst_round", 128'(round_out), 128'd0);
        repeat (2) drive_cycle(1'b0, rnd128());
        RST = 1'b1;
        repeat (3) drive_cycle(1'b0, rnd128());
        check("postrst_idle", 128'(busy_out), 128'd0);

        cur_key = KEY_C;
        drive_cycle(1'b1, PT_C);
        repeat (12) drive_cycle(1'b0, rnd128());
        check("postrst_valid_c", 128'(valid_out), 128'd1);
        check("postrst_ct_c", {ct0_out, ct1_out, ct2_out, ct3_out}, CT_C);
        repeat (3) drive_cycle(1'b0, rnd128());
        check("ct_hold", {ct0_out, ct1_out, ct2_out, ct3_out}, CT_C);
        check("valid_one_cycle", 128'(valid_out), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
